// File: rtl/quantdeser_pkg.sv
// Shared definitions for the quantised serial-to-parallel path: state encoding,
// default word sizes and their derived index widths.
package quantdeser_pkg;

  localparam int BDOUT_DEF   = 32;
  localparam int BDINMAX_DEF = 32;
  localparam int MSBW_DEF    = $clog2(BDOUT_DEF);
  localparam int BDINW_DEF   = $clog2(BDINMAX_DEF);

  typedef enum logic {
    IDLE  = 1'b0,
    SHIFT = 1'b1
  } state_t;

endpackage

// File: rtl/quantdeser_align.sv
// Places an N-bit serial word (first bit at acc[N-1]) so that its first bit
// lands on output bit msbidx, zero-fills below and zero/sign-fills above.
module quantdeser_align
  import quantdeser_pkg::*;
#(
  parameter int BDOUT   = BDOUT_DEF,
  parameter int BDINMAX = BDINMAX_DEF,
  parameter int MSBW    = $clog2(BDOUT),
  parameter int NW      = $clog2(BDINMAX) + 1
) (
  input  logic [BDINMAX-1:0] acc,
  input  logic [NW-1:0]      n,
  input  logic [MSBW-1:0]    msbidx,
  input  logic               signext,
  output logic [BDOUT-1:0]   aligned
);

  int   top_i;
  int   msb_i;
  logic first_bit;
  logic [BDOUT-1:0] wide;

  assign top_i = int'(n) - 1;
  assign msb_i = int'(msbidx);
  assign wide  = BDOUT'(acc);

  // acc holds only the N received bits (upper bits are zero), so a plain shift
  // both aligns the word and drops any bits that would fall below bit 0.
  always_comb begin
    first_bit = 1'b0;
    for (int i = 0; i < BDINMAX; i++) begin
      if (i == top_i) first_bit = acc[i];
    end

    if (top_i >= msb_i) aligned = wide >> (top_i - msb_i);
    else                aligned = wide << (msb_i - top_i);

    for (int j = 0; j < BDOUT; j++) begin
      if (j > msb_i) aligned[j] = signext & first_bit;
    end
  end

endmodule

// File: rtl/quantdeser.sv
// Serial-to-parallel deserialiser: collects N = bdin+1 bits MSB first and
// presents them aligned at msbidx with optional sign fill, one word per N cycles.
module quantdeser
  import quantdeser_pkg::*;
#(
  parameter int BDOUT   = BDOUT_DEF,
  parameter int BDINMAX = BDINMAX_DEF
) (
  input  logic                       clk,
  input  logic                       clr_n,
  input  logic                       clr,
  input  logic [$clog2(BDOUT)-1:0]   msbidx,
  input  logic [$clog2(BDINMAX)-1:0] bdin,
  input  logic                       signext,
  input  logic                       start,
  input  logic                       din,
  output logic [BDOUT-1:0]           dout,
  output logic                       valid,
  output logic                       busy
);

  localparam int MW = $clog2(BDOUT);
  localparam int BW = $clog2(BDINMAX);

  state_t             state;
  logic [BW-1:0]      cnt;
  logic [BW-1:0]      nm1_q;
  logic [MW-1:0]      msb_q;
  logic               sext_q;
  logic [BDINMAX-1:0] acc;

  logic               accept;
  logic               done;
  logic [BDINMAX-1:0] acc_next;
  logic [BW-1:0]      cfg_nm1;
  logic [MW-1:0]      cfg_msb;
  logic               cfg_sext;
  logic [BW:0]        cfg_n;
  logic [BDOUT-1:0]   aligned;

  assign accept = (state == IDLE) && start;

  // The final bit is folded in combinationally so the aligned word can be
  // registered on the very edge that samples it; a single-bit word therefore
  // has to use the live configuration inputs rather than the latched copies.
  assign acc_next = accept ? BDINMAX'(din) : {acc[BDINMAX-2:0], din};
  assign cfg_nm1  = accept ? bdin    : nm1_q;
  assign cfg_msb  = accept ? msbidx  : msb_q;
  assign cfg_sext = accept ? signext : sext_q;
  assign cfg_n    = (BW+1)'(cfg_nm1) + (BW+1)'(1);
  assign done     = accept ? (bdin == '0) : ((state == SHIFT) && (cnt == nm1_q));

  assign busy = (state == SHIFT);

  quantdeser_align #(
    .BDOUT   (BDOUT),
    .BDINMAX (BDINMAX)
  ) u_align (
    .acc     (acc_next),
    .n       (cfg_n),
    .msbidx  (cfg_msb),
    .signext (cfg_sext),
    .aligned (aligned)
  );

  // NOTE: every register here, accumulator included, is cleared by the async
  // reset and written only with non-blocking assignments.
  always_ff @(posedge clk or negedge clr_n) begin
    if (!clr_n) begin
      state  <= IDLE;
      cnt    <= '0;
      nm1_q  <= '0;
      msb_q  <= '0;
      sext_q <= 1'b0;
      acc    <= '0;
      dout   <= '0;
      valid  <= 1'b0;
    end else if (clr) begin
      state <= IDLE;
      cnt   <= '0;
      acc   <= '0;
      dout  <= '0;
      valid <= 1'b0;
    end else begin
      valid <= 1'b0;
      if (accept || (state == SHIFT)) acc <= acc_next;
      if (done) begin
        dout  <= aligned;
        valid <= 1'b1;
      end
      case (state)
        IDLE: begin
          if (start) begin
            nm1_q  <= bdin;
            msb_q  <= msbidx;
            sext_q <= signext;
            if (bdin != '0) begin
              state <= SHIFT;
              cnt   <= BW'(1);
            end
          end
        end
        SHIFT: begin
          if (cnt == nm1_q) begin
            state <= IDLE;
            cnt   <= '0;
          end else begin
            cnt <= cnt + BW'(1);
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_quantdeser.sv
// Scoreboarded bench for quantdeser: words are queued with their expected
// value and due cycle when driven, and checked by a monitor when valid rises.
module tb_quantdeser;

  logic        clk;
  logic        clr_n;
  logic        clr;
  logic [4:0]  msbidx;
  logic [4:0]  bdin;
  logic        signext;
  logic        start;
  logic        din;
  logic [31:0] dout;
  logic        valid;
  logic        busy;

  typedef struct {
    logic [31:0] word;
    int          due;
  } exp_t;

  exp_t exp_q[$];
  exp_t mon_e;
  int   cyc    = 0;
  int   checks = 0;
  int   errors = 0;

  quantdeser dut (
    .clk     (clk),
    .clr_n   (clr_n),
    .clr     (clr),
    .msbidx  (msbidx),
    .bdin    (bdin),
    .signext (signext),
    .start   (start),
    .din     (din),
    .dout    (dout),
    .valid   (valid),
    .busy    (busy)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  always @(posedge clk) begin
    #1;
    if (valid === 1'b1) begin
      checks++;
      if (exp_q.size() == 0) begin
        errors++;
        $display("FAIL unexpected_valid cyc=%0d dout=%h", cyc, dout);
      end else begin
        mon_e = exp_q.pop_front();
        if (dout !== mon_e.word) begin
          errors++;
          $display("FAIL dout_word cyc=%0d got=%h want=%h", cyc, dout, mon_e.word);
        end
        checks++;
        if (cyc !== mon_e.due) begin
          errors++;
          $display("FAIL valid_latency got_cyc=%0d want_cyc=%0d", cyc, mon_e.due);
        end
      end
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog_timeout cyc=%0d", cyc);
    $fatal(1, "watchdog");
  end

  function automatic logic [31:0] model(input int msb, input int nm1, input bit sx,
                                        input logic [31:0] bits);
    logic [31:0] r;
    logic        b0;
    r  = '0;
    b0 = bits[nm1];
    for (int k = 0; k <= nm1; k++) begin
      if (msb - k >= 0) r[msb-k] = bits[nm1-k];
    end
    for (int j = msb + 1; j < 32; j++) r[j] = sx & b0;
    return r;
  endfunction

  // bits[nm1] is the first serial bit; a start is re-asserted at ignored_at
  // (when >0) and configuration inputs are scrambled after acceptance.
  task automatic drive_word(input int msb, input int nm1, input bit sx,
                            input logic [31:0] bits, input logic [31:0] exp_word,
                            input int ignored_at);
    for (int k = 0; k <= nm1; k++) begin
      @(negedge clk);
      if (k == 0) begin
        checks++;
        if (busy !== 1'b0) begin
          errors++;
          $display("FAIL busy_at_start got=%b want=0", busy);
        end
        start   = 1'b1;
        msbidx  = 5'(msb);
        bdin    = 5'(nm1);
        signext = sx;
        exp_q.push_back('{word: exp_word, due: cyc + nm1 + 1});
      end else begin
        checks++;
        if (busy !== 1'b1) begin
          errors++;
          $display("FAIL busy_mid_word k=%0d got=%b want=1", k, busy);
        end
        start   = (k == ignored_at);
        msbidx  = 5'($urandom);
        bdin    = 5'($urandom);
        signext = 1'($urandom);
      end
      din = bits[nm1-k];
    end
  endtask

  task automatic idle_cycles(input int n);
    repeat (n) begin
      @(negedge clk);
      start  = 1'b0;
      din    = 1'($urandom);
      msbidx = 5'($urandom);
      bdin   = 5'($urandom);
    end
  endtask

  task automatic wait_drain(input string tag);
    int n;
    n = 0;
    @(negedge clk);
    start = 1'b0;
    while (exp_q.size() != 0 && n < 100) begin
      @(negedge clk);
      n++;
    end
    checks++;
    if (exp_q.size() != 0) begin
      errors++;
      $display("FAIL drain_%s pending=%0d want=0", tag, exp_q.size());
      exp_q.delete();
    end
  endtask

  task automatic test_reset();
    #3;
    checks++;
    if (dout !== 32'h0 || valid !== 1'b0 || busy !== 1'b0) begin
      errors++;
      $display("FAIL reset_outputs dout=%h valid=%b busy=%b want 0/0/0", dout, valid, busy);
    end
    repeat (3) @(negedge clk);
    clr_n = 1'b1;
    idle_cycles(2);
    checks++;
    if (dout !== 32'h0 || valid !== 1'b0 || busy !== 1'b0) begin
      errors++;
      $display("FAIL post_reset_idle dout=%h valid=%b busy=%b want 0/0/0", dout, valid, busy);
    end
  endtask

  task automatic test_single_bit();
    drive_word(0, 0, 1'b0, 32'h1, 32'h0000_0001, -1);
    repeat (3) begin
      @(negedge clk);
      start = 1'b0;
      checks++;
      if (busy !== 1'b0) begin
        errors++;
        $display("FAIL busy_single_bit got=%b want=0", busy);
      end
    end
    wait_drain("single_bit");
  endtask

  task automatic test_two_bit();
    drive_word(3, 1, 1'b0, 32'b10, 32'h0000_0008, -1);
    wait_drain("two_bit");
  endtask

  task automatic test_full_width_back_to_back();
    drive_word(31, 31, 1'b0, 32'h5, 32'h0000_0005, -1);
    drive_word(15, 7, 1'b1, 32'hC3, model(15, 7, 1'b1, 32'hC3), -1);
    wait_drain("full_width");
  endtask

  task automatic test_signext();
    drive_word(7, 3, 1'b1, 32'b1011, 32'hFFFF_FFB0, -1);
    wait_drain("signext");
  endtask

  task automatic test_discard();
    drive_word(1, 3, 1'b0, 32'b1011, 32'h0000_0002, 2);
    wait_drain("discard");
  endtask

  task automatic test_async_reset_midword();
    logic [7:0] bits;
    bits = 8'hA5;
    @(negedge clk);
    start = 1'b1; msbidx = 5'd7; bdin = 5'd7; signext = 1'b0; din = bits[7];
    @(negedge clk);
    start = 1'b0; din = bits[6];
    @(negedge clk);
    start = 1'b1; msbidx = 5'd0; bdin = 5'd0; din = bits[5];
    @(negedge clk);
    start = 1'b0; din = bits[4];
    checks++;
    if (dout === 32'h0) begin
      errors++;
      $display("FAIL pre_reset_dout got=%h want=nonzero", dout);
    end
    #2 clr_n = 1'b0;
    #1;
    checks++;
    if (dout !== 32'h0 || valid !== 1'b0 || busy !== 1'b0) begin
      errors++;
      $display("FAIL async_reset_midword dout=%h valid=%b busy=%b want 0/0/0", dout, valid, busy);
    end
    @(negedge clk);
    clr_n = 1'b1;
    idle_cycles(3);
    drive_word(7, 7, 1'b0, 32'hA5, 32'h0000_00A5, 2);
    wait_drain("after_reset");
  endtask

  task automatic test_sync_clr();
    drive_word(20, 5, 1'b1, 32'h2D, model(20, 5, 1'b1, 32'h2D), -1);
    wait_drain("pre_clr");
    @(negedge clk);
    start = 1'b1; msbidx = 5'd10; bdin = 5'd5; signext = 1'b0; din = 1'b1;
    @(negedge clk);
    start = 1'b0; din = 1'b0;
    @(negedge clk);
    clr = 1'b1; start = 1'b1; bdin = 5'd0; msbidx = 5'd0; din = 1'b1;
    @(negedge clk);
    checks++;
    if (dout !== 32'h0 || valid !== 1'b0 || busy !== 1'b0) begin
      errors++;
      $display("FAIL sync_clr dout=%h valid=%b busy=%b want 0/0/0", dout, valid, busy);
    end
    clr = 1'b0; start = 1'b0;
    idle_cycles(8);
  endtask

  task automatic test_back_to_back_random();
    int          msb;
    int          nm1;
    bit          sx;
    logic [31:0] bits;
    for (int w = 0; w < 10; w++) begin
      msb  = int'($urandom_range(0, 31));
      nm1  = int'($urandom_range(0, 15));
      sx   = 1'($urandom);
      bits = $urandom;
      drive_word(msb, nm1, sx, bits, model(msb, nm1, sx, bits), (w % 3 == 0) ? 1 : -1);
    end
    wait_drain("random");
  endtask

  initial begin
    clr_n = 1'b0; clr = 1'b0; start = 1'b0; din = 1'b0;
    msbidx = '0; bdin = '0; signext = 1'b0;
    test_reset();
    test_single_bit();
    test_two_bit();
    test_full_width_back_to_back();
    test_signext();
    test_discard();
    test_async_reset_midword();
    test_sync_clr();
    test_back_to_back_random();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/quantdeser.md
QUANTDESER -- requirements
Module: quantdeser

Interface
REQ-001 Parameter BDOUT, default 32, SHALL set the parallel output word width.
REQ-002 Parameter BDINMAX, default 32, SHALL set the maximum serial word length in bits, with BDINMAX <= BDOUT.
REQ-003 Port clk, input, 1, SHALL be the single clock; all state updates on its rising edge.
REQ-004 Port clr_n, input, 1, SHALL be the asynchronous, active-low reset.
REQ-005 Port clr, input, 1, SHALL be a synchronous active-high abort/clear.
REQ-006 Port msbidx, input, clog2(BDOUT), SHALL give the output bit position receiving the first serial bit.
REQ-007 Port bdin, input, clog2(BDINMAX), SHALL give serial length minus 1 (N = bdin+1).
REQ-008 Port signext, input, 1, SHALL request that output bits above msbidx be filled with the first serial bit.
REQ-009 Port start, input, 1, SHALL request a new word; the first serial bit is present on din in the start cycle.
REQ-010 Port din, input, 1, SHALL carry serial data MSB first.
REQ-011 Port dout, output, BDOUT, SHALL hold the last completed aligned word.
REQ-012 Port valid, output, 1, SHALL pulse high for one cycle when dout is updated.
REQ-013 Port busy, output, 1, SHALL be high while remaining serial bits are outstanding.

Function
REQ-014 The FSM SHALL have exactly two states: IDLE and SHIFT.
REQ-015 In IDLE with start=1, the block SHALL latch msbidx, bdin and signext, sample din as bit 0, and go to SHIFT if N>1 or stay in IDLE if N=1.
REQ-016 In SHIFT, the block SHALL sample din every cycle, count bits, and return to IDLE in the cycle the Nth bit is sampled.
REQ-017 Serial bit k (k=0 first) SHALL map to dout[msbidx-k]; a bit whose index is negative SHALL be discarded.
REQ-018 dout bits below msbidx-N+1 SHALL be 0.
REQ-019 dout bits above msbidx SHALL be 0 when signext=0 and equal to bit 0 when signext=1.
REQ-020 valid and the new dout SHALL appear in the cycle after the Nth bit is sampled, giving latency N cycles from start.
REQ-021 dout SHALL hold its value until the next completion, reset or clr.
REQ-022 start asserted while busy=1 SHALL be ignored.
REQ-023 start SHALL be accepted in the same cycle valid is high, allowing back-to-back words at one word per N cycles.
REQ-024 busy SHALL equal (state==SHIFT).
REQ-025 clr=1 SHALL force IDLE, dout=0 and valid=0 at the next edge, and SHALL take priority over start.
REQ-026 Inputs that change after acceptance SHALL NOT affect the word in progress.

Reset
REQ-027 clr_n=0 SHALL asynchronously force state=IDLE, bit counter=0, accumulator=0, dout=0, valid=0 and busy=0, including mid-word.
REQ-028 After clr_n deasserts, the first rising edge with start=1 SHALL begin a new word normally.

Structure
REQ-029 A shared package SHALL hold the state enum, the default BDOUT/BDINMAX constants and their clog2-derived widths, for reuse by quantser-side logic and benches.
REQ-030 The final alignment and fill SHALL be a combinational sub-module named quantdeser_align (inputs: accumulator, N, msbidx, signext; output: aligned word).

Verification
REQ-031 The bench SHALL cover N=1, msbidx=0, din=1 -> dout=32'h00000001, valid high 1 cycle after start, busy never high.
REQ-032 The bench SHALL cover N=2, msbidx=3, bits 1,0 -> dout=32'h00000008, valid high 2 cycles after start.
REQ-033 The bench SHALL cover N=32, msbidx=31, serial pattern of 5 MSB first -> dout=32'h00000005, valid high 32 cycles after start, with a second start in the valid cycle accepted.
REQ-034 The bench SHALL cover signext=1, N=4, msbidx=7, bits 1,0,1,1 -> dout=32'hFFFFFFB0.
REQ-035 The bench SHALL cover N=4, msbidx=1, bits 1,0,1,1 -> dout=32'h00000002.
REQ-036 The bench SHALL cover N=8 with clr_n pulsed low at cycle 3 -> dout=0, valid=0, busy=0 immediately, a start at cycle 2 of a word ignored, and a next word decoding correctly.
